// File: rtl/edge_pkg.sv
// Shared definitions for the pixel source: FSM states, pixel width and the
// channel offsets inside a packed {R,G,B} memory word.
package edge_pkg;

  localparam int PIX_W = 8;
  localparam int RGB_W = 3 * PIX_W;
  localparam int R_OFF = 2 * PIX_W;
  localparam int G_OFF = PIX_W;
  localparam int B_OFF = 0;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter with end-of-line and end-of-frame detection.
// x wraps at W-1, at which point y advances (and wraps at H-1).
module raster_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          x_last,
  output logic          frame_last
);

  logic y_last;

  assign x_last     = (x == XW'(W - 1));
  assign y_last     = (y == YW'(H - 1));
  assign frame_last = x_last && y_last;

  // Position update: clear on frame start, step one pixel per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Frame-memory reader that streams one frame of RGB pixels in raster order,
// then (with PIXEL_STREAM_FLUSH_EN defined) appends FLUSH_CNT zero pixels to
// drain downstream line buffers. Read data returns one cycle after mem_rd and
// is forwarded combinationally alongside the registered write strobe.
module pixel_stream_source
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int BASE_ADDR  = 0,
  parameter int FLUSH_CNT  = 4 * IMG_WIDTH + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [RGB_W-1:0]  mem_rdata,
  output logic              write,
  output logic [PIX_W-1:0]  out_r,
  output logic [PIX_W-1:0]  out_g,
  output logic [PIX_W-1:0]  out_b,
  output logic              sof,
  output logic              eol,
  output logic              busy,
  output logic              done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  if (IMG_WIDTH < 2)  begin : g_chk_w $error("IMG_WIDTH must be >= 2");  end
  if (IMG_HEIGHT < 1) begin : g_chk_h $error("IMG_HEIGHT must be >= 1"); end
  if (FLUSH_CNT < 0)  begin : g_chk_f $error("FLUSH_CNT must be >= 0");  end

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_last, frame_last;
  logic          rd_d, sof_d, eol_d;
  logic          flush_wr;

  assign mem_rd = (state == STREAM) && !pause;

  raster_counter #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT),
    .XW(XW),
    .YW(YW)
  ) u_raster (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       ((state == IDLE) && start),
    .adv       (mem_rd),
    .x         (x),
    .y         (y),
    .x_last    (x_last),
    .frame_last(frame_last)
  );

`ifdef PIXEL_STREAM_FLUSH_EN
  localparam int FCW = $clog2(FLUSH_CNT + 2);
  logic [FCW-1:0] fcnt;

  assign flush_wr = (state == FLUSH) && !pause;

  // Frame sequencing with flush tail; busy/done registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mem_addr <= ADDR_W'(BASE_ADDR);
            busy     <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: if (!pause) begin
          mem_addr <= mem_addr + 1'b1;
          if (frame_last) state <= DRAIN;
        end
        DRAIN: begin
          if (FLUSH_CNT > 0) begin
            fcnt  <= FCW'(FLUSH_CNT);
            state <= FLUSH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        FLUSH: if (!pause) begin
          if (fcnt == FCW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
          fcnt <= fcnt - 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign flush_wr = 1'b0;

  // Frame sequencing without flush tail; busy/done registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mem_addr <= ADDR_W'(BASE_ADDR);
            busy     <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: if (!pause) begin
          mem_addr <= mem_addr + 1'b1;
          if (frame_last) state <= DRAIN;
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  // Read-return pipeline: write and frame markers follow mem_rd by one cycle;
  // reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d  <= 1'b0;
      sof_d <= 1'b0;
      eol_d <= 1'b0;
    end else begin
      rd_d  <= mem_rd;
      sof_d <= mem_rd && (x == '0) && (y == '0);
      eol_d <= mem_rd && x_last;
    end
  end

  // Flush pixels carry zero channels and no markers.
  assign write = rd_d | flush_wr;
  assign out_r = rd_d ? mem_rdata[R_OFF +: PIX_W] : '0;
  assign out_g = rd_d ? mem_rdata[G_OFF +: PIX_W] : '0;
  assign out_b = rd_d ? mem_rdata[B_OFF +: PIX_W] : '0;
  assign sof   = sof_d;
  assign eol   = eol_d;

endmodule
